uart_tx_arb: RTL and testbench
==============================

UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters sharing one uart_tx; legal range 2..8.
REQ-002 Parameter DATA_W, default 32: word width passed to uart_tx.
REQ-003 Port i_clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 Port i_rst, input, 1: reset, synchronous and active-high.
REQ-005 Port i_en, input, N_REQ: per-requester enable mask; a disabled requester is never granted.
REQ-006 Port i_req_valid, input, N_REQ: requester n has a word pending.
REQ-007 Port i_req_data, input, N_REQ x DATA_W: word of requester n.
REQ-008 Port o_req_accept, output, N_REQ: one-hot pulse; the word of requester n is taken this cycle.
REQ-009 Port o_tx_data, output, DATA_W: word presented to uart_tx i_data.
REQ-010 Port o_tx_valid, output, 1: drives uart_tx i_valid.
REQ-011 Port i_tx_accept, input, 1: from uart_tx o_accept.
REQ-012 Port o_grant_id, output, clog2(N_REQ): index of the requester owning the current/last transfer.
REQ-013 Port o_busy, output, 1: high while in state SEND.

Function
REQ-014 States IDLE and SEND only; state typedef lives in the package.
REQ-015 IDLE: candidates = i_req_valid & i_en; if none, remain in IDLE with all o_req_accept low.
REQ-016 IDLE with candidates: the grant is the first candidate found searching upward from (last_grant+1) mod N_REQ, wrapping.
REQ-017 In the grant cycle: o_req_accept[g]=1 (only that bit), i_req_data[g] captured into a hold register, o_grant_id<=g, last_grant<=g, next state SEND.
REQ-018 SEND: o_tx_valid=1, o_tx_data=hold register, both stable until the handshake.
REQ-019 Handshake occurs when o_tx_valid && i_tx_accept; on the handshake edge the next state is IDLE, and o_tx_valid is low in the following cycle.
REQ-020 Latency: requester valid in cycle 0 -> accept pulse in cycle 0 -> o_tx_valid in cycle 1; minimum two cycles per word (one IDLE bubble after each handshake).
REQ-021 i_tx_accept while in IDLE is ignored.
REQ-022 Changes to i_en or i_req_valid during SEND do not affect the transfer in flight; they affect only the next arbitration.
REQ-023 A requester deasserting valid before it is granted is simply not granted; no stored state.
REQ-024 All requesters continuously valid -> grants rotate strictly 0,1,...,N_REQ-1,0,...; no requester waits more than N_REQ transfers.
REQ-025 o_req_accept is never asserted in SEND; it is at most one-hot.

Reset
REQ-026 Reset values: state IDLE, o_tx_valid=0, o_req_accept=0, o_busy=0, o_tx_data=0, o_grant_id=0, last_grant=N_REQ-1 (so requester 0 has first priority).
REQ-027 Reset asserted during SEND aborts the transfer: o_tx_valid=0 in the cycle after the reset edge, and the held word is discarded.
REQ-028 While i_rst is high, no o_req_accept is issued, irrespective of requests.

Structure
REQ-029 Package uart_tx_arb_pkg holds the state enum (IDLE, SEND) and the N_REQ/DATA_W defaults.
REQ-030 The rotating priority search is a purely combinational sub-module rr_pick, with inputs candidates and last_grant and outputs found and grant index.
REQ-031 The top level holds the state register, hold register and last_grant register; it instantiates exactly one rr_pick.

Verification
REQ-032 Reset, then i_req_valid=4'b0001, data 0xDEADBEEF, i_tx_accept=0 -> accept[0] pulses in cycle 0; o_tx_valid=1 with 0xDEADBEEF from cycle 1, held until i_tx_accept=1.
REQ-033 All four requesters valid, i_en=4'hF, i_tx_accept tied 1 -> grant order 0,1,2,3,0; one accept every 2 cycles.
REQ-034 i_en=4'b1010 with all valid -> grants alternate only 1 and 3; accept[0] and accept[2] stay low.
REQ-035 During SEND with last_grant=1, raise valid on 0 and 3 -> next grant is 3, then 0 (wrap).
REQ-036 Reset pulse in mid-SEND holding 0x12345678 -> o_tx_valid low the next cycle; after reset, requester 0 is granted first when 0 and 2 are both valid.
REQ-037 Assertion checks for every scenario: o_req_accept is one-hot or zero, and o_tx_data is stable while o_tx_valid && !i_tx_accept.

Source files
------------

// File: rtl/uart_tx_arb_pkg.sv
// Shared types and defaults for the round-robin front end of a single uart_tx.
package uart_tx_arb_pkg;

   localparam int N_REQ_DEF  = 4;
   localparam int DATA_W_DEF = 32;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } arb_state_t;

endpackage

// File: rtl/uart_tx_arb_rr_pick.sv
// Rotating-priority search: first set candidate at or after (last_grant+1) mod N_REQ.
module rr_pick
   import uart_tx_arb_pkg::*;
#(
   parameter int N_REQ = N_REQ_DEF,
   parameter int GW    = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] candidates,
   input  logic [GW-1:0]    last_grant,
   output logic             found,
   output logic [GW-1:0]    grant
);

   logic [GW:0] sum;

   // One extra bit keeps last_grant + offset (< 2*N_REQ) exact, so a single
   // conditional subtract performs the modulo for any N_REQ, power of two or not.
   always_comb begin
      found = 1'b0;
      grant = '0;
      sum   = '0;
      for (int k = 0; k < N_REQ; k++) begin
         sum = {1'b0, last_grant} + (GW+1)'(k + 1);
         if (sum >= (GW+1)'(N_REQ))
            sum = sum - (GW+1)'(N_REQ);
         if (!found && candidates[sum[GW-1:0]]) begin
            found = 1'b1;
            grant = sum[GW-1:0];
         end
      end
   end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter feeding one uart_tx: grants a requester, holds its word until handshake.
module uart_tx_arb
   import uart_tx_arb_pkg::*;
#(
   parameter int N_REQ  = N_REQ_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic                           i_clk,
   input  logic                           i_rst,
   input  logic [N_REQ-1:0]               i_en,
   input  logic [N_REQ-1:0]               i_req_valid,
   input  logic [N_REQ-1:0][DATA_W-1:0]   i_req_data,
   output logic [N_REQ-1:0]               o_req_accept,
   output logic [DATA_W-1:0]              o_tx_data,
   output logic                           o_tx_valid,
   input  logic                           i_tx_accept,
   output logic [$clog2(N_REQ)-1:0]       o_grant_id,
   output logic                           o_busy
);

   localparam int GW = $clog2(N_REQ);

   arb_state_t        state_q, state_d;
   logic [DATA_W-1:0] hold_q;
   logic [GW-1:0]     last_grant_q;
   logic [GW-1:0]     grant_id_q;
   logic [GW-1:0]     pick;
   logic [N_REQ-1:0]  candidates;
   logic              found;
   logic              grant_fire;

   assign candidates = i_req_valid & i_en;

   rr_pick #(.N_REQ(N_REQ), .GW(GW)) u_rr_pick (
      .candidates (candidates),
      .last_grant (last_grant_q),
      .found      (found),
      .grant      (pick)
   );

   always_comb begin
      state_d      = state_q;
      o_req_accept = '0;
      grant_fire   = 1'b0;
      case (state_q)
         IDLE: begin
            // No grant while reset is held, even though the state is still IDLE.
            if (found && !i_rst) begin
               grant_fire         = 1'b1;
               o_req_accept[pick] = 1'b1;
               state_d            = SEND;
            end
         end
         SEND: begin
            if (i_tx_accept)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q      <= IDLE;
         hold_q       <= '0;
         grant_id_q   <= '0;
         last_grant_q <= GW'(N_REQ - 1);
      end else begin
         state_q <= state_d;
         if (grant_fire) begin
            hold_q       <= i_req_data[pick];
            grant_id_q   <= pick;
            last_grant_q <= pick;
         end
      end
   end

   assign o_tx_valid = (state_q == SEND);
   assign o_busy     = (state_q == SEND);
   assign o_tx_data  = hold_q;
   assign o_grant_id = grant_id_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb: hand-computed grant orders, latency, reset abort.
module tb_uart_tx_arb;

   logic               i_clk = 1'b0;
   logic               i_rst;
   logic [3:0]         i_en;
   logic [3:0]         i_req_valid;
   logic [3:0][31:0]   i_req_data;
   logic [3:0]         o_req_accept;
   logic [31:0]        o_tx_data;
   logic               o_tx_valid;
   logic               i_tx_accept;
   logic [1:0]         o_grant_id;
   logic               o_busy;

   int checks   = 0;
   int failures = 0;

   uart_tx_arb #(.N_REQ(4), .DATA_W(32)) dut (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .i_en         (i_en),
      .i_req_valid  (i_req_valid),
      .i_req_data   (i_req_data),
      .o_req_accept (o_req_accept),
      .o_tx_data    (o_tx_data),
      .o_tx_valid   (o_tx_valid),
      .i_tx_accept  (i_tx_accept),
      .o_grant_id   (o_grant_id),
      .o_busy       (o_busy)
   );

   always #5 i_clk = ~i_clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Inputs change 1 time unit after the rising edge; outputs are sampled at the falling edge.
   task automatic nxt();
      @(posedge i_clk);
      #1;
   endtask

   task automatic smp();
      @(negedge i_clk);
   endtask

   // One grant to requester g: accept pulse in the IDLE cycle, word presented the next cycle.
   task automatic expect_grant(input int g);
      smp();
      chk($sformatf("accept_g%0d", g), 32'(o_req_accept), 32'(1) << g);
      nxt();
      smp();
      chk($sformatf("txv_g%0d", g), 32'(o_tx_valid), 32'h1);
      chk($sformatf("txd_g%0d", g), o_tx_data, i_req_data[g]);
      chk($sformatf("gid_g%0d", g), 32'(o_grant_id), 32'(g));
      nxt();
   endtask

   task automatic do_reset();
      i_rst       = 1'b1;
      i_req_valid = 4'h0;
      nxt();
      i_rst = 1'b0;
   endtask

   // Invariants on every cycle: accept at most one-hot and never while busy; word held stable.
   logic        p_v, p_a, p_r;
   logic [31:0] p_d;
   initial begin
      p_v = 1'b0; p_a = 1'b0; p_r = 1'b1; p_d = '0;
      forever begin
         @(negedge i_clk);
         chk("acc_1hot", 32'($onehot0(o_req_accept) && !(o_busy && (|o_req_accept))), 32'h1);
         if (p_v && !p_a && !p_r) begin
            chk("txv_hold", 32'(o_tx_valid), 32'h1);
            chk("txd_hold", o_tx_data, p_d);
         end
         p_v = o_tx_valid;
         p_a = i_tx_accept;
         p_r = i_rst;
         p_d = o_tx_data;
      end
   end

   initial begin
      i_rst       = 1'b1;
      i_en        = 4'hF;
      i_req_valid = 4'hF;
      i_tx_accept = 1'b0;
      i_req_data  = '0;
      #1;
      smp();
      chk("rst_acc",  32'(o_req_accept), 32'h0);
      chk("rst_txv",  32'(o_tx_valid), 32'h0);
      chk("rst_busy", 32'(o_busy), 32'h0);
      chk("rst_txd",  o_tx_data, 32'h0);
      chk("rst_gid",  32'(o_grant_id), 32'h0);
      nxt();

      // Single requester, latency and hold until handshake
      i_rst         = 1'b0;
      i_req_valid   = 4'b0001;
      i_req_data[0] = 32'hDEADBEEF;
      smp();
      chk("s1_acc",  32'(o_req_accept), 32'h1);
      chk("s1_txv0", 32'(o_tx_valid), 32'h0);
      nxt();
      i_req_valid = 4'b0000;
      for (int k = 0; k < 3; k++) begin
         smp();
         chk("s1_txv",  32'(o_tx_valid), 32'h1);
         chk("s1_txd",  o_tx_data, 32'hDEADBEEF);
         chk("s1_busy", 32'(o_busy), 32'h1);
         nxt();
      end
      i_tx_accept = 1'b1;
      smp();
      chk("s1_txv_hs", 32'(o_tx_valid), 32'h1);
      nxt();
      // Accept while idle with nothing pending must not start anything
      for (int k = 0; k < 2; k++) begin
         smp();
         chk("idle_txv",  32'(o_tx_valid), 32'h0);
         chk("idle_busy", 32'(o_busy), 32'h0);
         nxt();
      end

      // All valid, all enabled, sink always ready: 0,1,2,3,0
      do_reset();
      for (int n = 0; n < 4; n++) i_req_data[n] = 32'hA0A0_0000 | 32'(n);
      i_en        = 4'hF;
      i_req_valid = 4'hF;
      i_tx_accept = 1'b1;
      expect_grant(0);
      expect_grant(1);
      expect_grant(2);
      expect_grant(3);
      expect_grant(0);

      // Mask 1010: only 1 and 3 alternate
      i_en = 4'b1010;
      expect_grant(1);
      expect_grant(3);
      expect_grant(1);
      expect_grant(3);

      // Grant 1, then raise 0 and 3 during SEND: wrap gives 3 then 0
      i_en        = 4'hF;
      i_req_valid = 4'b0010;
      i_tx_accept = 1'b0;
      smp();
      chk("s4_acc1", 32'(o_req_accept), 32'h2);
      nxt();
      i_req_valid = 4'b1001;
      smp();
      chk("s4_txv", 32'(o_tx_valid), 32'h1);
      chk("s4_txd", o_tx_data, 32'hA0A0_0001);
      nxt();
      i_tx_accept = 1'b1;
      smp();
      chk("s4_gid", 32'(o_grant_id), 32'h1);
      nxt();
      expect_grant(3);
      expect_grant(0);
      i_req_valid = 4'b0000;

      // Reset in mid-SEND aborts the word; requester 0 first afterwards
      i_req_data[2] = 32'h12345678;
      i_req_valid   = 4'b0100;
      i_tx_accept   = 1'b0;
      smp();
      chk("s5_acc2", 32'(o_req_accept), 32'h4);
      nxt();
      i_req_valid = 4'b0000;
      smp();
      chk("s5_txv", 32'(o_tx_valid), 32'h1);
      chk("s5_txd", o_tx_data, 32'h12345678);
      nxt();
      i_rst       = 1'b1;
      i_req_valid = 4'b0101;
      smp();
      chk("s5_rst_acc", 32'(o_req_accept), 32'h0);
      nxt();
      i_rst = 1'b0;
      smp();
      chk("s5_txv_abort", 32'(o_tx_valid), 32'h0);
      chk("s5_busy",      32'(o_busy), 32'h0);
      chk("s5_txd_clr",   o_tx_data, 32'h0);
      chk("s5_acc0",      32'(o_req_accept), 32'h1);
      nxt();
      smp();
      chk("s5_txd0", o_tx_data, 32'hA0A0_0000);
      chk("s5_gid0", 32'(o_grant_id), 32'h0);
      nxt();
      i_req_valid = 4'b0000;
      repeat (2) nxt();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
